// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin grant arbiter.
// Used by rr_pick_8 and rr_grant_arbiter_8.
package rr_arb_pkg;

   localparam int NREQ  = 8;
   localparam int IDX_W = 3;

   // Holding 7 here makes the first search after reset begin at requester 0.
   localparam logic [IDX_W-1:0] LAST_IDX_RST = 3'd7;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin pick: the first set request found searching upward
// from last_idx+1, wrapping 7 -> 0, with last_idx itself searched last.
module rr_pick_8
   import rr_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last_idx,
   output logic             found,
   output logic [IDX_W-1:0] winner_idx
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest offset to the nearest so the nearest hit overwrites.
   always_comb begin
      found      = 1'b0;
      winner_idx = '0;
      cand       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = last_idx + IDX_W'(i + 1);
         if (req[cand]) begin
            found      = 1'b1;
            winner_idx = cand;
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and index.
// Define RR_GRANT_ARBITER_HOLD_LIMIT_EN to revoke grants held for MAX_HOLD cycles.
module rr_grant_arbiter_8 #(
   parameter int NREQ     = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [2:0]      grant_idx,
   output logic            grant_valid,
   output logic            timeout
);

   import rr_arb_pkg::*;

   if (NREQ != 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
      $error("rr_grant_arbiter_8: NREQ must be 8 and MAX_HOLD within 2..255");
   end

   arb_state_e       state_q, state_nxt;
   logic [NREQ-1:0]  grant_q, grant_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt;
   logic [IDX_W-1:0] last_q, last_nxt;
   logic             found;
   logic [IDX_W-1:0] win_idx;

`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] cnt_q, cnt_nxt;
   logic       to_q, to_nxt;
`endif

   rr_pick_8 u_pick (
      .req        (req),
      .last_idx   (last_q),
      .found      (found),
      .winner_idx (win_idx)
   );

   always_comb begin
      state_nxt = state_q;
      grant_nxt = grant_q;
      idx_nxt   = idx_q;
      last_nxt  = last_q;
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
      cnt_nxt   = cnt_q;
      to_nxt    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (en && found) begin
               state_nxt = GRANT;
               idx_nxt   = win_idx;
               grant_nxt = idx_to_onehot(win_idx);
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
               cnt_nxt   = '0;
`endif
            end
         end
         GRANT: begin
            // A dropped request wins over en=0 and over the hold limit; all revoke alike.
            if (!req[idx_q] || !en) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               idx_nxt   = '0;
               last_nxt  = idx_q;
            end
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
            else if (cnt_q == HOLD_LAST) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               idx_nxt   = '0;
               last_nxt  = idx_q;
               to_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         last_q  <= LAST_IDX_RST;
      end else begin
         state_q <= state_nxt;
         grant_q <= grant_nxt;
         idx_q   <= idx_nxt;
         last_q  <= last_nxt;
      end
   end

`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         to_q  <= to_nxt;
      end
   end

   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// Scoreboard bench for rr_grant_arbiter_8; honours RR_GRANT_ARBITER_HOLD_LIMIT_EN.
`timescale 1ns/1ps
module tb_rr_grant_arbiter_8;

   localparam int TB_HOLD = 4;

   typedef struct {
      logic [7:0] g;
      logic [2:0] i;
      logic       v;
      logic       t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t sb[$];

   // Reference model state
   bit       m_valid;
   logic [2:0] m_idx;
   logic [2:0] m_last;
   int       m_cnt;
   bit       m_to;

   rr_grant_arbiter_8 #(.NREQ(8), .MAX_HOLD(TB_HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_idx   = 3'd0;
      m_last  = 3'd7;
      m_cnt   = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input logic e, input logic [7:0] r);
      bit         hit;
      logic [2:0] cand;
      hit  = 1'b0;
      m_to = 1'b0;
      if (!m_valid) begin
         if (e) begin
            for (int k = 1; k <= 8; k++) begin
               cand = 3'((int'(m_last) + k) % 8);
               if (!hit && r[cand]) begin
                  hit   = 1'b1;
                  m_idx = cand;
               end
            end
         end
         if (hit) begin
            m_valid = 1'b1;
            m_cnt   = 0;
         end
      end else if (!r[m_idx] || !e) begin
         m_last  = m_idx;
         m_valid = 1'b0;
         m_idx   = 3'd0;
      end
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
      else if (m_cnt == TB_HOLD - 1) begin
         m_last  = m_idx;
         m_valid = 1'b0;
         m_idx   = 3'd0;
         m_to    = 1'b1;
      end else begin
         m_cnt = m_cnt + 1;
      end
`endif
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic cycle(input logic e, input logic [7:0] r);
      exp_t x, y;
      en  = e;
      req = r;
      model_step(e, r);
      x.g = m_valid ? (8'h01 << m_idx) : 8'h00;
      x.i = m_idx;
      x.v = m_valid;
      x.t = m_to;
      sb.push_back(x);
      @(posedge clk);
      #1;
      y = sb.pop_front();
      check_eq("grant", 32'(grant), 32'(y.g));
      check_eq("grant_idx", 32'(grant_idx), 32'(y.i));
      check_eq("grant_valid", 32'(grant_valid), 32'(y.v));
      check_eq("timeout", 32'(timeout), 32'(y.t));
      check_eq("onehot", 32'($countones(grant) <= 1), 32'd1);
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_grant"}, 32'(grant), 32'd0);
      check_eq({tag, "_idx"}, 32'(grant_idx), 32'd0);
      check_eq({tag, "_valid"}, 32'(grant_valid), 32'd0);
      check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   // Called at a negedge; releases reset at a later negedge.
   task automatic do_reset(input logic e, input logic [7:0] r);
      en    = e;
      req   = r;
      rst_n = 1'b0;
      #1;
      check_zero("rst_async");
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      logic [2:0] seq[16];
      int         nseq;
      int         hold;
      bit         prev_v;
      int         n_to;
      logic [2:0] alt_exp[4];
      alt_exp[0] = 3'd2; alt_exp[1] = 3'd5; alt_exp[2] = 3'd2; alt_exp[3] = 3'd5;

      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;
      model_reset();
      @(negedge clk);

      // Reset with all requesting; first grant goes to 0
      do_reset(1'b1, 8'hFF);
      cycle(1'b1, 8'hFF);
      check_eq("first_grant", 32'(grant), 32'h01);

      // Two requesters, 3-cycle holds: 2,5,2,5
      do_reset(1'b1, 8'h24);
      hold = 0; nseq = 0; prev_v = 1'b0;
      for (int c = 0; c < 24; c++) begin
         r = 8'h24;
         if (m_valid && hold == 3) r[m_idx] = 1'b0;
         cycle(1'b1, r);
         if (grant_valid && !prev_v && nseq < 16) begin
            seq[nseq] = grant_idx;
            nseq++;
         end
         prev_v = grant_valid;
         hold = m_valid ? hold + 1 : 0;
      end
      check_eq("alt_count", 32'(nseq >= 4), 32'd1);
      for (int k = 0; k < 4; k++) check_eq("alt_seq", 32'(seq[k]), 32'(alt_exp[k]));

      // en low aborts grant on 3; re-grant starts at 4
      do_reset(1'b1, 8'h18);
      cycle(1'b1, 8'h18);
      check_eq("abort_hold_idx", 32'(grant_idx), 32'd3);
      cycle(1'b1, 8'h18);
      cycle(1'b1, 8'h18);
      for (int c = 0; c < 4; c++) cycle(1'b0, 8'h18);
      check_eq("abort_no_grant", 32'(grant_valid), 32'd0);
      cycle(1'b1, 8'h18);
      check_eq("regrant_idx", 32'(grant_idx), 32'd4);

      // Simultaneous release and en=0 acts as a release
      do_reset(1'b1, 8'h03);
      cycle(1'b1, 8'h03);
      cycle(1'b0, 8'h02);
      cycle(1'b1, 8'h03);
      check_eq("simul_next_idx", 32'(grant_idx), 32'd1);

      // Wrap search to 7, drop and re-raise
      do_reset(1'b1, 8'h80);
      cycle(1'b1, 8'h80);
      check_eq("wrap_idx", 32'(grant_idx), 32'd7);
      cycle(1'b1, 8'h80);
      cycle(1'b1, 8'h00);
      check_eq("wrap_gap", 32'(grant_valid), 32'd0);
      cycle(1'b1, 8'h80);
      check_eq("wrap_regrant", 32'(grant_idx), 32'd7);

      // Async reset between edges mid-grant
      do_reset(1'b1, 8'h40);
      cycle(1'b1, 8'h40);
      cycle(1'b1, 8'h40);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midgrant_rst");
      model_reset();
      req = 8'h42;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 8'h42);
      check_eq("post_rst_idx", 32'(grant_idx), 32'd1);

      // All eight with 1-cycle holds: 0..7,0
      do_reset(1'b1, 8'hFF);
      nseq = 0; prev_v = 1'b0;
      for (int c = 0; c < 20; c++) begin
         r = 8'hFF;
         if (m_valid) r[m_idx] = 1'b0;
         cycle(1'b1, r);
         if (grant_valid && !prev_v && nseq < 16) begin
            seq[nseq] = grant_idx;
            nseq++;
         end
         prev_v = grant_valid;
      end
      check_eq("rr_count", 32'(nseq >= 9), 32'd1);
      for (int k = 0; k < 9; k++) check_eq("rr_seq", 32'(seq[k]), 32'(k % 8));

      // Hold limit with two steady requesters
      do_reset(1'b1, 8'h03);
      n_to = 0;
      for (int c = 0; c < 14; c++) begin
         cycle(1'b1, 8'h03);
         if (timeout) n_to++;
      end
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
      check_eq("timeout_count", 32'(n_to), 32'd2);
`else
      check_eq("timeout_count", 32'(n_to), 32'd0);
`endif
      check_eq("hold_final_idx", 32'(grant_idx), 32'd0);
      check_eq("hold_final_valid", 32'(grant_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter_8.md
Name: rr_grant_arbiter_8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Issues a registered one-hot grant plus its 3-bit encoded index: bit i of grant ⇔ grant_idx = i, same one-hot→binary mapping as the team's 8-to-3 encoder.
- Sits in front of any shared datapath resource (bus, register port, DMA channel); the holder keeps the grant until it drops its request.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 for this revision (index width 3).
- MAX_HOLD, 16, grant-hold limit in cycles; used only when the optional feature is compiled in; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbiter enable; low blocks new grants and revokes the current one.
- req  in  8  request vector, level-sensitive, bit i = requester i.
- grant  out  8  one-hot grant, registered.
- grant_idx  out  3  binary index of the granted requester, registered; 0 when no grant.
- grant_valid  out  1  high while any grant is held.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit; tied 0 without the feature.

Behaviour:
- Reset (async assert, sync release):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - state=IDLE, last_idx=7, so the first search starts at requester 0.
- FSM states: IDLE, GRANT.
- IDLE → GRANT:
  - Condition at edge k: en=1 and |req=1.
  - Winner = first set req bit searching last_idx+1, last_idx+2, … modulo 8 (wraps 7→0).
  - grant, grant_idx and grant_valid are visible after edge k (1-cycle latency from req sampled).
- GRANT hold: stays while en=1 and req[grant_idx]=1; other req changes are ignored.
- GRANT → IDLE (release):
  - Trigger: req[grant_idx]=0 at an edge.
  - Outputs clear at that edge; last_idx ← grant_idx.
  - Next grant is no earlier than the following edge, so there is a mandatory 1-cycle gap with grant_valid=0.
- GRANT → IDLE (abort):
  - Trigger: en=0 at an edge.
  - Outputs clear at that edge; last_idx ← grant_idx.
  - No new grant while en=0; requests stay pending.
- Simultaneous release and en=0: treated as a single release, identical result.
- Single requester: re-granted after every 1-cycle gap; no starvation of itself.
- All 8 requesting continuously with 1-cycle holds: grant order 0,1,…,7,0 with a gap after each.
- Invariants:
  - grant == (1 << grant_idx) when grant_valid=1.
  - grant==0 and grant_idx==0 when grant_valid=0.
  - Never more than one grant bit set.
- Reset mid-grant: outputs clear immediately (asynchronous); last_idx returns to 7.

Optional Feature:
- Macro: RR_GRANT_ARBITER_HOLD_LIMIT_EN.
- With the macro:
  - An 8-bit hold counter clears on IDLE→GRANT and increments each cycle in GRANT.
  - When grant_valid has been high for MAX_HOLD cycles, the grant is revoked at that edge as a release.
  - last_idx ← grant_idx, and timeout pulses high for exactly that following cycle.
  - The revoked requester cannot win the next arbitration if any other request is pending.
- Without the macro:
  - No counter is instantiated; timeout is constant 0.
  - Grants are held indefinitely while req stays high.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - constants NREQ=8 and IDX_W=3;
  - the reset value LAST_IDX_RST=3'd7.
- Sub-module rr_pick_8: purely combinational rotate-and-priority-encode.
  - Inputs: req, last_idx. Outputs: found, winner_idx.
  - The top level decodes winner_idx to one-hot.

Test Plan:
- Reset with req=8'hFF, en=1 → outputs 0 during reset; 1 cycle after release grant=8'h01, grant_idx=0, grant_valid=1.
- req=8'b0010_0100 held, each holder drops req after 3 grant cycles → grants alternate idx 2, 5, 2, 5 with a 1-cycle gap between each.
- Grant held on idx 3, pull en low for 4 cycles → grant clears next edge; no grant while en=0; re-grant 1 cycle after en=1 starts search at idx 4.
- req=8'h80 only, last_idx=7 → wrap search grants idx 7; drop and re-raise → idx 7 re-granted after a 1-cycle gap.
- Assert rst_n low mid-grant, between clock edges → grant, grant_idx, grant_valid drop immediately; first post-reset winner is the lowest set req bit from 0.
- With RR_GRANT_ARBITER_HOLD_LIMIT_EN, MAX_HOLD=4, req=8'h03 held high → idx0 for 4 cycles, timeout pulse, gap, then idx1 for 4 cycles, timeout; without the macro idx0 is held forever.
